// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the FSM state encoding and the fetch queue sizing.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int INST_BYTES   = 4;
    localparam int FETCH_QDEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_queue.sv
// Two-entry FIFO of {pc, inst} between the fetch FSM and decode.
// Entry 0 is always the head, so the head outputs come straight from a register.
module pc_fetch_queue
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_inst,
    input  logic        pop,
    input  logic        flush,
    output logic [1:0]  count,
    output logic        head_valid,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);

    localparam logic [1:0] QFULL = 2'(FETCH_QDEPTH);

    fetch_entry_t e0;
    fetch_entry_t e1;
    fetch_entry_t din;
    logic         do_push;
    logic         do_pop;

    assign din     = '{pc: push_pc, inst: push_inst};
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != QFULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // simultaneous push/pop keeps occupancy; new word lands behind the survivor
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_pc    = e0.pc;
    assign head_inst  = e0.inst;

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, single-outstanding fetch FSM, 2-entry queue.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects raise sticky fetch_misaligned and park fetch.
//
//   state | meaning
//   IDLE  | post-reset bubble, or parked after a misaligned redirect
//   REQ   | presenting pc to imem while the queue has room
//   WAIT  | one request outstanding; drop_next marks its response as stale
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fetch_misaligned
);

    localparam logic [1:0] QFULL = 2'(FETCH_QDEPTH);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  req_pc, req_pc_n;
    logic         drop_next, drop_n;
    logic         push;
    logic         hs;
    logic         owed;
    logic [1:0]   count;
    logic [31:0]  redir_tgt;
    logic         redir_mis;
    logic         mis_q;

    assign redir_tgt = redirect_pc & ~32'h3;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_mis = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset)               mis_q <= 1'b0;
        else if (redirect_valid) mis_q <= redir_mis;
    end
`else
    assign redir_mis = 1'b0;
    assign mis_q     = 1'b0;
`endif

    assign fetch_misaligned = mis_q;
    assign imem_req_valid   = (state == REQ) && (count < QFULL);
    assign imem_req_addr    = pc;
    assign hs               = imem_req_valid && imem_req_ready;
    // a redirect still owes one response if memory has accepted a request we have not heard back from
    assign owed             = ((state == WAIT) && !imem_rsp_valid) || hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            drop_next <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            req_pc    <= req_pc_n;
            drop_next <= drop_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        drop_n   = drop_next;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!mis_q) state_n = REQ;
            end
            REQ: begin
                if (hs) begin
                    pc_n     = pc + 32'(INST_BYTES);
                    req_pc_n = pc;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_n = 1'b0;
                    if (drop_next) begin
                        state_n = mis_q ? IDLE : REQ;
                    end else begin
                        push    = 1'b1;
                        state_n = REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (redirect_valid) begin
            push    = 1'b0;
            pc_n    = redir_tgt;
            drop_n  = owed;
            state_n = owed ? WAIT : (redir_mis ? IDLE : REQ);
        end
    end

    pc_fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_pc   (req_pc),
        .push_inst (imem_rsp_data),
        .pop       (inst_ready),
        .flush     (redirect_valid),
        .count     (count),
        .head_valid(inst_valid),
        .head_pc   (inst_pc),
        .head_inst (inst_data)
    );

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus a randomized run,
// all checked against a transaction-level model (owed response + expected queue of PCs).
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_misaligned;

    pc_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          pops  = 0;
    logic        const_mode;
    logic        junk_en;
    int          dly_lo, dly_hi;

    // reference model state
    logic [31:0] q[$];
    logic [31:0] hs_log[$];
    logic [31:0] exp_addr;
    logic [31:0] owed_addr;
    logic        owed, stale, exp_mis;
    int          dly;
    int          idle_left;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (const_mode) return 32'h0000_0013;
        return (a ^ 32'h5A5A_0000) + {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        owed      = 1'b0;
        stale     = 1'b0;
        exp_mis   = 1'b0;
        exp_addr  = 32'h0;
        idle_left = 1;
        dly       = 0;
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance the model one clock.
    task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy, input logic irdy);
        logic exp_req, rv, junk, hs, pop;
        exp_req = (idle_left == 0) && !owed && !exp_mis && (q.size() < 2);
        chk("req_valid", imem_req_valid, exp_req);
        if (exp_req) chk("req_addr", imem_req_addr, exp_addr);
        chk("inst_valid", inst_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("inst_pc", inst_pc, q[0]);
            chk("inst_data", inst_data, memf(q[0]));
        end
        chk("misaligned", fetch_misaligned, exp_mis);

        rv   = owed && (dly == 0);
        junk = !owed && junk_en && ($urandom_range(7, 0) == 0);
        imem_rsp_valid = rv || junk;
        imem_rsp_data  = rv ? memf(owed_addr) : 32'hDEAD_BEEF;
        imem_req_ready = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = irdy;

        hs  = exp_req && rdy;
        pop = irdy && (q.size() > 0);
        if (!redir && pop) begin
            void'(q.pop_front());
            pops++;
        end
        if (rv) begin
            if (!redir && !stale) q.push_back(owed_addr);
            owed  = 1'b0;
            stale = 1'b0;
        end else if (owed) begin
            if (dly > 0) dly--;
            if (redir) stale = 1'b1;
        end
        if (hs) begin
            if (!redir) hs_log.push_back(exp_addr);
            owed      = 1'b1;
            stale     = redir;
            owed_addr = exp_addr;
            dly       = $urandom_range(dly_hi, dly_lo);
        end
        if (redir) begin
            q.delete();
            exp_addr = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_mis = (rpc[1:0] != 2'b00);
`endif
        end else if (hs) begin
            exp_addr = exp_addr + 32'd4;
        end
        if (idle_left > 0) idle_left--;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic irdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, irdy);
    endtask

    initial begin
        logic [31:0] tgt;
        int          guard;
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        const_mode = 1'b1;
        junk_en    = 1'b0;
        dly_lo = 0;
        dly_hi = 0;

        // reset values, with a stray response held high throughout
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misaligned", fetch_misaligned, 1'b0);
        reset = 1'b0;
        imem_rsp_valid = 1'b0;
        model_reset();

        // basic streaming with a 1-cycle memory
        hs_log.delete();
        run(8, 1'b1);
        chk("t1_nreq", hs_log.size() >= 3, 1'b1);
        if (hs_log.size() >= 3) begin
            chk("t1_req0", hs_log[0], 32'h0);
            chk("t1_req1", hs_log[1], 32'h4);
            chk("t1_req2", hs_log[2], 32'h8);
        end

        // decode stall: queue fills to two and fetch stops
        run(10, 1'b0);
        chk("t2_stall_req", imem_req_valid, 1'b0);
        chk("t2_stall_valid", inst_valid, 1'b1);
        run(8, 1'b1);

        // redirect while a response is outstanding
        const_mode = 1'b0;
        dly_lo = 2;
        dly_hi = 2;
        guard = 0;
        while (!owed && guard < 20) begin
            run(1, 1'b1);
            guard++;
        end
        chk("t3_reached_wait", owed, 1'b1);
        cyc(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        chk("t3_flushed", inst_valid, 1'b0);
        hs_log.delete();
        run(10, 1'b1);
        chk("t3_nreq", hs_log.size() > 0, 1'b1);
        if (hs_log.size() > 0) chk("t3_target", hs_log[0], 32'h0000_0100);

        // redirect coinciding with a response and a pop
        dly_lo = 0;
        dly_hi = 0;
        guard = 0;
        while (!(owed && q.size() == 1) && guard < 20) begin
            run(1, 1'b0);
            guard++;
        end
        chk("t4_setup", owed && q.size() == 1, 1'b1);
        cyc(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        chk("t4_no_push", inst_valid, 1'b0);
        hs_log.delete();
        run(6, 1'b1);
        chk("t4_nreq", hs_log.size() > 0, 1'b1);
        if (hs_log.size() > 0) chk("t4_target", hs_log[0], 32'h0000_0300);

        // pc wrap at the top of the address space
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        hs_log.delete();
        run(8, 1'b1);
        chk("t5_nreq", hs_log.size() >= 2, 1'b1);
        if (hs_log.size() >= 2) begin
            chk("t5_top", hs_log[0], 32'hFFFF_FFFC);
            chk("t5_wrap", hs_log[1], 32'h0);
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        cyc(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        hs_log.delete();
        run(8, 1'b1);
        chk("t6_flag", fetch_misaligned, 1'b1);
        chk("t6_no_req", hs_log.size(), 32'd0);
        cyc(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        hs_log.delete();
        run(8, 1'b1);
        chk("t6_cleared", fetch_misaligned, 1'b0);
        chk("t6_nreq", hs_log.size() > 0, 1'b1);
        if (hs_log.size() > 0) chk("t6_target", hs_log[0], 32'h0000_0200);
`else
        // without the trap, low redirect bits are simply ignored
        cyc(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        hs_log.delete();
        run(8, 1'b1);
        chk("t6_flag_tied", fetch_misaligned, 1'b0);
        chk("t6_nreq", hs_log.size() > 0, 1'b1);
        if (hs_log.size() > 0) chk("t6_aligned", hs_log[0], 32'h0000_0100);
`endif

        // randomized traffic
        junk_en = 1'b1;
        dly_lo = 0;
        dly_hi = 3;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r   = ($urandom_range(24, 0) == 0);
            tgt = ($urandom_range(5, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                              : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            tgt = tgt & ~32'h3;
`endif
            cyc(r, tgt, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
        end
        chk("rand_progress", pops > 200, 1'b1);

        // mid-operation reset with a late response during reset
        guard = 0;
        while (!owed && guard < 20) begin
            run(1, 1'b1);
            guard++;
        end
        reset = 1'b1;
        imem_rsp_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", inst_valid, 1'b0);
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        reset = 1'b0;
        imem_rsp_valid = 1'b1;
        model_reset();
        junk_en = 1'b0;
        hs_log.delete();
        run(10, 1'b1);
        chk("mid_rst_nreq", hs_log.size() > 0, 1'b1);
        if (hs_log.size() > 0) chk("mid_rst_restart", hs_log[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
